iir_stream_tx: RTL and testbench

- Synchronous stream transmitter that feeds the `vIn`/`dIn` input port of `iir_filter`.
- It accepts samples from an upstream producer over a valid/ready handshake and buffers them in a small FIFO.
- It emits them as a single-cycle-valid stream (`vOut`/`dOut`) with a programmable idle gap between samples, then signals completion after a programmed sample count.
- It is the synthesizable, back-pressure-aware counterpart of the filter's output sink, so the filter can be driven on-chip and not only from a bench.

---
 rtl/iir_stream_pkg.sv | 17 +
 rtl/iir_stream_tx_fifo.sv | 57 +++++
 rtl/iir_stream_tx.sv | 135 +++++++++++++
 tb/tb_iir_stream_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_stream_pkg.sv
// Shared definitions for the iir_filter stream transmitter: FSM state
// encoding and default sizing constants shared with iir_filter benches.
package iir_stream_pkg;

  localparam int NB_DEF    = 12;
  localparam int DEPTH_DEF = 8;
  localparam int GAPW_DEF  = 4;
  localparam int CNTW_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/iir_stream_tx_fifo.sv
// sync_fifo: single-clock FIFO without fall-through. The head word is read
// combinationally from storage, so a word written on one edge is only
// visible (and poppable) from the next cycle on. A separate occupancy
// count distinguishes full from empty; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int NB    = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [NB-1:0]              wdata,
  output logic [NB-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int unsigned FULL_CNT = DEPTH;

  logic [NB-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT[AW:0]);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iir_stream_tx.sv
// iir_stream_tx: buffers upstream samples (valid/ready) in a sync_fifo and
// replays them to iir_filter as single-cycle vOut/dOut pulses with a
// programmable idle gap, signalling done after n_samples.
// Optional macro IIR_TX_UFLOW_CNT_EN adds a saturating uflow_cnt[7:0] port.
module iir_stream_tx
  import iir_stream_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int GAPW  = GAPW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NB-1:0]   s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            start,
  input  logic [CNTW-1:0] n_samples,
  input  logic [GAPW-1:0] gap,
  output logic [NB-1:0]   dOut,
  output logic            vOut,
  output logic            busy,
  output logic            done,
`ifdef IIR_TX_UFLOW_CNT_EN
  output logic [7:0]      uflow_cnt,
`endif
  output logic            underflow
);

  tx_state_t               state;
  logic [CNTW-1:0]         n_lat;
  logic [CNTW-1:0]         cnt;
  logic [GAPW-1:0]         gap_lat;
  logic [GAPW-1:0]         gcnt;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic [NB-1:0]           fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_count_unused;

  // Occupancy is exported by the FIFO for debug; flow control uses full/empty.
  assign fifo_count_unused = ^fifo_count;

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;
  assign fifo_pop  = (state == RUN) && !fifo_empty;

  sync_fifo #(
    .NB    (NB),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Transfer FSM with gap counter and registered stream/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_lat     <= '0;
      cnt       <= '0;
      gap_lat   <= '0;
      gcnt      <= '0;
      dOut      <= '0;
      vOut      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underflow <= 1'b0;
`ifdef IIR_TX_UFLOW_CNT_EN
      uflow_cnt <= '0;
`endif
    end else begin
      vOut <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_lat     <= n_samples;
            gap_lat   <= gap;
            cnt       <= '0;
            underflow <= 1'b0;
`ifdef IIR_TX_UFLOW_CNT_EN
            uflow_cnt <= '0;
`endif
            if (n_samples == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (!fifo_empty) begin
            dOut <= fifo_rdata;
            vOut <= 1'b1;
            cnt  <= cnt + 1'b1;
            if (cnt + 1'b1 == n_lat) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (gap_lat != '0) begin
              gcnt  <= gap_lat;
              state <= GAP;
            end
          end else begin
            underflow <= 1'b1;
`ifdef IIR_TX_UFLOW_CNT_EN
            if (uflow_cnt != 8'hFF) uflow_cnt <= uflow_cnt + 1'b1;
`endif
          end
        end
        GAP: begin
          if (gcnt == GAPW'(1)) state <= RUN;
          else                  gcnt  <= gcnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_stream_tx.sv
// Self-checking bench for iir_stream_tx. The reference model tracks the
// expected FIFO contents as a queue, the remaining sample count and the
// earliest edge at which the next sample may be emitted.
module tb_iir_stream_tx;

  localparam int NB    = 12;
  localparam int DEPTH = 8;
  localparam int GAPW  = 4;
  localparam int CNTW  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NB-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic            start = 1'b0;
  logic [CNTW-1:0] n_samples = '0;
  logic [GAPW-1:0] gap = '0;
  logic [NB-1:0]   dOut;
  logic            vOut;
  logic            busy;
  logic            done;
  logic            underflow;
`ifdef IIR_TX_UFLOW_CNT_EN
  logic [7:0]      uflow_cnt;
`endif

  iir_stream_tx #(
    .NB    (NB),
    .DEPTH (DEPTH),
    .GAPW  (GAPW),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .start     (start),
    .n_samples (n_samples),
    .gap       (gap),
    .dOut      (dOut),
    .vOut      (vOut),
    .busy      (busy),
    .done      (done),
`ifdef IIR_TX_UFLOW_CNT_EN
    .uflow_cnt (uflow_cnt),
`endif
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_m = 0;

  // reference model state
  logic [NB-1:0] mq[$];
  logic [NB-1:0] feed_q[$];
  int            m_rem  = 0;
  int            m_gap  = 0;
  int            m_next = 0;
  int            m_ucnt = 0;
  bit            m_uflow = 0;
  bit            m_done  = 0;
  bit            m_vout  = 0;
  logic [NB-1:0] m_dout  = '0;
  bit            rnd_valid = 0;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_m, obs, exp);
    end
  endfunction

  // One clock edge: advance the model with the inputs currently driven,
  // then compare every output #1 after the edge.
  task automatic tick(output bit acc);
    int te;
    bit rdy_b, busy_b;
    bit e_busy, e_rdy;
    acc = 0;
    te  = cyc_m + 1;
    if (rst_n) begin
      rdy_b  = (mq.size() < DEPTH);
      busy_b = (m_rem > 0);
      m_vout = 0;
      if (busy_b && te >= m_next) begin
        if (mq.size() > 0) begin
          m_dout = mq.pop_front();
          m_vout = 1;
          m_rem--;
          m_next = te + m_gap + 1;
          if (m_rem == 0) m_done = 1;
        end else begin
          m_uflow = 1;
          if (m_ucnt < 255) m_ucnt++;
        end
      end
      if (s_valid && rdy_b) begin
        mq.push_back(s_data);
        acc = 1;
      end
      if (start && !busy_b) begin
        m_rem   = int'(n_samples);
        m_gap   = int'(gap);
        m_next  = te + 1;
        m_uflow = 0;
        m_ucnt  = 0;
        m_done  = (n_samples == '0);
      end
    end
    cyc_m = te;
    @(posedge clk);
    #1;
    e_busy = (m_rem > 0);
    e_rdy  = (mq.size() < DEPTH);
    chk("vOut", vOut, m_vout);
    chk("dOut", dOut, m_dout);
    chk("busy", busy, e_busy);
    chk("done", done, m_done);
    chk("underflow", underflow, m_uflow);
    chk("s_ready", s_ready, e_rdy);
`ifdef IIR_TX_UFLOW_CNT_EN
    chk("uflow_cnt", uflow_cnt, 8'(m_ucnt));
`endif
  endtask

  // Drive the next pending upstream sample (if any), clock once, clear start.
  task automatic step();
    bit acc;
    s_valid = (feed_q.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
    if (s_valid) s_data = feed_q[0];
    tick(acc);
    if (acc) void'(feed_q.pop_front());
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic feed_rand(input int n);
    for (int i = 0; i < n; i++) feed_q.push_back(NB'($urandom));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk("xfer_wait_expired", (k < budget) || (done === 1'b1), 1'b1);
    chk("xfer_done", done, 1'b1);
  endtask

  task automatic run_xfer(input int n, input int g, input int budget);
    n_samples = CNTW'(n);
    gap       = GAPW'(g);
    start     = 1'b1;
    step();
    wait_done(budget);
  endtask

  // Assert reset between edges and check that outputs clear immediately.
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    feed_q.delete();
    m_rem = 0; m_done = 0; m_uflow = 0; m_ucnt = 0; m_vout = 0; m_dout = '0;
    chk("rst_vOut", vOut, 1'b0);
    chk("rst_dOut", dOut, 12'h000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // power-on reset
    step();
    step();
    rst_n = 1'b1;
    step();

    // back-to-back stream of 0x001..0x004
    for (int i = 1; i <= 4; i++) feed_q.push_back(NB'(i));
    repeat (4) step();
    run_xfer(4, 0, 50);
    chk("b2b_underflow", underflow, 1'b0);

    // reset from DONE with non-zero dOut
    reset_mid();

    // backpressure: 10 offered with FSM idle, only 8 fit
    feed_rand(10);
    repeat (10) step();
    chk("bp_s_ready", s_ready, 1'b0);
    // gap spacing: 10 samples, gap 3, last 2 fed while running
    run_xfer(10, 3, 200);

    // 12 samples back-to-back through a full FIFO
    feed_rand(8);
    repeat (8) step();
    feed_rand(4);
    run_xfer(12, 0, 100);

    // underflow: start on empty FIFO, samples arrive 5 cycles later
    n_samples = 16'd3;
    gap       = 4'd0;
    start     = 1'b1;
    step();
    repeat (4) step();
    feed_rand(3);
    wait_done(50);
    chk("uflow_sticky", underflow, 1'b1);
`ifdef IIR_TX_UFLOW_CNT_EN
    chk("uflow_cnt_5", uflow_cnt, 8'd5);
`endif

    // zero-length transfer
    n_samples = 16'd0;
    start     = 1'b1;
    step();
    chk("n0_done", done, 1'b1);
    chk("n0_vOut", vOut, 1'b0);
    step();

    // start pulse during RUN is ignored
    feed_rand(6);
    repeat (6) step();
    n_samples = 16'd6;
    gap       = 4'd1;
    start     = 1'b1;
    step();
    repeat (3) step();
    n_samples = 16'd2;
    start     = 1'b1;
    step();
    wait_done(100);

    // reset during GAP discards FIFO and transfer
    feed_rand(4);
    repeat (4) step();
    n_samples = 16'd4;
    gap       = 4'd5;
    start     = 1'b1;
    step();
    repeat (2) step();
    chk("gap_busy", busy, 1'b1);
    reset_mid();
    repeat (3) step();
    n_samples = 16'd1;
    gap       = 4'd0;
    start     = 1'b1;
    step();
    repeat (2) step();
    chk("post_rst_empty", underflow, 1'b1);
    feed_rand(1);
    wait_done(50);

    // randomized transfers with irregular upstream valid
    rnd_valid = 1;
    for (int it = 0; it < 5; it++) begin
      int n, g;
      n = int'($urandom_range(1, 12));
      g = int'($urandom_range(0, 3));
      feed_rand(n);
      run_xfer(n, g, 400);
    end
    rnd_valid = 0;
    repeat (3) step();

    if (bad != 0) $error("test FAILED: total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
